// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and load/store; ARB_RR_EN selects round-robin arbitration
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic if_gnt,
  output logic if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic ls_req,
  input  logic ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic ls_gnt,
  output logic ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic mem_en,
  output logic mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic owner;
  logic [1:0] lat_cnt;
  logic ls_win;
  logic done;
  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: RAM_LAT=%0d outside 1..4", RAM_LAT);
  end
`ifdef ARB_RR_EN
  logic prio;
  // a contested grant goes to the favoured requester (prio=1 favours LS)
  always_comb ls_win = ls_req && (!if_req || prio);
  // favour whichever requester did not win the latest grant
  always_ff @(posedge clk or negedge rst)
    if (!rst) prio <= 1'b1;
    else if (mem_en) prio <= if_gnt;
`else
  // load/store always beats fetch
  always_comb ls_win = ls_req;
`endif
  // grants, RAM strobes and read return; all forced low while reset is held
  always_comb begin
    ls_gnt = rst && state == IDLE && ls_win;
    if_gnt = rst && state == IDLE && if_req && !ls_win;
    mem_en = ls_gnt || if_gnt;
    mem_we = ls_gnt && ls_we;
    mem_addr = ls_gnt ? ls_addr : if_gnt ? if_addr : '0;
    mem_wdata = ls_gnt ? ls_wdata : '0;
    busy = rst && state == WAIT;
    done = busy && lat_cnt == 2'd0;
    if_rvalid = done && !owner;
    ls_rvalid = done && owner;
    if_rdata = if_rvalid ? mem_rdata : '0;
    ls_rdata = ls_rvalid ? mem_rdata : '0;
  end
  // reads move IDLE to WAIT; WAIT counts down the RAM latency and returns to IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      lat_cnt <= 2'd0;
    end else if (state == IDLE) begin
      if (if_gnt || (ls_gnt && !ls_we)) begin
        state <= WAIT;
        owner <= ls_gnt;
        lat_cnt <= 2'(RAM_LAT - 1);
      end
    end else begin
      lat_cnt <= lat_cnt == 2'd0 ? 2'd0 : lat_cnt - 2'd1;
      if (lat_cnt == 2'd0) state <= IDLE;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (RAM_LAT 1..3) under directed and random traffic against a cycle-level model
module tb_mem_port_arbiter;
  localparam int N = 3;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] if_req = '0, ls_req = '0, ls_we = '0;
  logic [N-1:0] if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_addr [N], ls_addr [N], ls_wdata [N], mem_rdata [N];
  logic [31:0] if_rdata [N], ls_rdata [N], mem_addr [N], mem_wdata [N];
  int checks = 0, errors = 0;
  int wl [N];
  bit own [N], pr [N], seen_ig [N], seen_lg [N];
  logic [7:0] lh, ih;
  int rv_cnt;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.RAM_LAT(g + 1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]),
      .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // wl counts cycles until the read result is due; 0 means free to arbitrate
  task automatic model_check();
    for (int k = 0; k < N; k++) begin
      logic eig, elg, eirv, elrv, ebusy;
      logic [31:0] eaddr, ewd;
      eig = 0; elg = 0; eirv = 0; elrv = 0; ebusy = 0; eaddr = 0; ewd = 0;
      if (rst) begin
        if (wl[k] > 0) begin
          ebusy = 1;
          if (wl[k] == 1) begin elrv = own[k]; eirv = !own[k]; end
        end else if (if_req[k] && ls_req[k]) begin
          elg = RR ? pr[k] : 1'b1;
          eig = !elg;
        end else begin
          elg = ls_req[k];
          eig = if_req[k];
        end
      end
      if (elg) begin eaddr = ls_addr[k]; ewd = ls_wdata[k]; end
      else if (eig) eaddr = if_addr[k];
      chk($sformatf("k%0d if_gnt", k), 32'(if_gnt[k]), 32'(eig));
      chk($sformatf("k%0d ls_gnt", k), 32'(ls_gnt[k]), 32'(elg));
      chk($sformatf("k%0d mem_en", k), 32'(mem_en[k]), 32'(eig | elg));
      chk($sformatf("k%0d mem_we", k), 32'(mem_we[k]), 32'(elg & ls_we[k]));
      chk($sformatf("k%0d mem_addr", k), mem_addr[k], eaddr);
      chk($sformatf("k%0d mem_wdata", k), mem_wdata[k], ewd);
      chk($sformatf("k%0d busy", k), 32'(busy[k]), 32'(ebusy));
      chk($sformatf("k%0d if_rvalid", k), 32'(if_rvalid[k]), 32'(eirv));
      chk($sformatf("k%0d ls_rvalid", k), 32'(ls_rvalid[k]), 32'(elrv));
      chk($sformatf("k%0d if_rdata", k), if_rdata[k], eirv ? mem_rdata[k] : 32'd0);
      chk($sformatf("k%0d ls_rdata", k), ls_rdata[k], elrv ? mem_rdata[k] : 32'd0);
      seen_ig[k] = if_gnt[k];
      seen_lg[k] = ls_gnt[k];
      if (!rst) begin
        wl[k] = 0; pr[k] = 1; own[k] = 0;
      end else if (wl[k] > 0) wl[k]--;
      else if (eig || elg) begin
        pr[k] = eig;
        if (eig || !ls_we[k]) begin wl[k] = k + 1; own[k] = elg; end
      end
    end
  endtask
  task automatic observe();
    @(negedge clk);
    model_check();
  endtask
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_reqs();
    if_req = '0; ls_req = '0; ls_we = '0;
    for (int k = 0; k < N; k++) begin
      if_addr[k] = '0; ls_addr[k] = '0; ls_wdata[k] = '0; mem_rdata[k] = '0;
    end
  endtask
  task automatic do_reset();
    clear_reqs();
    rst = 0;
    observe();
    step_clk();
    rst = 1;
  endtask
  // requesters hold until granted (occasionally giving up); RAM data is noise each cycle
  task automatic drive_rand();
    for (int k = 0; k < N; k++) begin
      if (!(if_req[k] && !seen_ig[k] && $urandom_range(15) != 0)) begin
        if_req[k] = 1'($urandom_range(1));
        if_addr[k] = $urandom;
      end
      if (!(ls_req[k] && !seen_lg[k] && $urandom_range(15) != 0)) begin
        ls_req[k] = 1'($urandom_range(1));
        ls_we[k] = 1'($urandom_range(1));
        ls_addr[k] = $urandom;
        ls_wdata[k] = $urandom;
      end
      mem_rdata[k] = $urandom;
    end
  endtask
  initial begin
    do_reset();
    // single fetch, RAM_LAT=1
    if_req[0] = 1; if_addr[0] = 32'h1C; mem_rdata[0] = 32'h12345678;
    observe();
    chk("p2 c0 if_gnt", 32'(if_gnt[0]), 1);
    chk("p2 c0 mem_en", 32'(mem_en[0]), 1);
    chk("p2 c0 mem_addr", mem_addr[0], 32'h1C);
    chk("p2 c0 mem_we", 32'(mem_we[0]), 0);
    step_clk();
    if_req[0] = 0; mem_rdata[0] = 32'hDEADBEEF;
    observe();
    chk("p2 c1 if_rvalid", 32'(if_rvalid[0]), 1);
    chk("p2 c1 if_rdata", if_rdata[0], 32'hDEADBEEF);
    chk("p2 c1 busy", 32'(busy[0]), 1);
    step_clk();
    observe();
    chk("p2 c2 busy", 32'(busy[0]), 0);
    step_clk();
    // contested load vs fetch, RAM_LAT=2
    do_reset();
    if_req[1] = 1; if_addr[1] = 32'h100;
    ls_req[1] = 1; ls_we[1] = 0; ls_addr[1] = 32'h40; mem_rdata[1] = 32'hA5A50001;
    observe();
    chk("p3 c0 ls_gnt", 32'(ls_gnt[1]), 1);
    chk("p3 c0 if_gnt", 32'(if_gnt[1]), 0);
    chk("p3 c0 mem_addr", mem_addr[1], 32'h40);
    step_clk();
    ls_req[1] = 0;
    observe(); step_clk();
    observe();
    chk("p3 c2 ls_rvalid", 32'(ls_rvalid[1]), 1);
    chk("p3 c2 ls_rdata", ls_rdata[1], 32'hA5A50001);
    step_clk();
    observe();
    chk("p3 c3 if_gnt", 32'(if_gnt[1]), 1);
    chk("p3 c3 mem_addr", mem_addr[1], 32'h100);
    step_clk();
    if_req[1] = 0; mem_rdata[1] = 32'h0BADF00D;
    observe(); step_clk();
    observe();
    chk("p3 c5 if_rvalid", 32'(if_rvalid[1]), 1);
    chk("p3 c5 if_rdata", if_rdata[1], 32'h0BADF00D);
    step_clk();
    // back-to-back stores
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ls_req[0] = 1; ls_we[0] = 1; ls_addr[0] = 32'(16 + 4 * i); ls_wdata[0] = 32'(i + 1);
      observe();
      chk($sformatf("p4 st%0d ls_gnt", i), 32'(ls_gnt[0]), 1);
      chk($sformatf("p4 st%0d mem_we", i), 32'(mem_we[0]), 1);
      chk($sformatf("p4 st%0d mem_addr", i), mem_addr[0], 32'(16 + 4 * i));
      chk($sformatf("p4 st%0d mem_wdata", i), mem_wdata[0], 32'(i + 1));
      chk($sformatf("p4 st%0d busy", i), 32'(busy[0]), 0);
      step_clk();
    end
    clear_reqs();
    observe();
    chk("p4 after ls_rvalid", 32'(ls_rvalid[0]), 0);
    step_clk();
    // both reads held continuously, RAM_LAT=1
    do_reset();
    if_req[0] = 1; if_addr[0] = 32'h200; ls_req[0] = 1; ls_we[0] = 0; ls_addr[0] = 32'h300;
    for (int c = 0; c < 8; c++) begin
      observe();
      lh[c] = ls_gnt[0];
      ih[c] = if_gnt[0];
      step_clk();
    end
    chk("p5 ls grant pattern", 32'(lh), RR ? 32'h11 : 32'h55);
    chk("p5 if grant pattern", 32'(ih), RR ? 32'h44 : 32'h00);
    // reset while a RAM_LAT=3 load is in flight
    do_reset();
    ls_req[2] = 1; ls_we[2] = 0; ls_addr[2] = 32'h80;
    observe();
    chk("p6 c0 ls_gnt", 32'(ls_gnt[2]), 1);
    step_clk();
    ls_req[2] = 0;
    observe();
    chk("p6 c1 busy", 32'(busy[2]), 1);
    step_clk();
    rst = 0;
    observe();
    chk("p6 rst busy", 32'(busy[2]), 0);
    step_clk();
    rst = 1; if_req[2] = 1; if_addr[2] = 32'h44;
    observe();
    chk("p6 first if_gnt", 32'(if_gnt[2]), 1);
    step_clk();
    if_req[2] = 0;
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      observe();
      rv_cnt += int'(ls_rvalid[2]);
      step_clk();
    end
    chk("p6 ls_rvalid pulses", 32'(rv_cnt), 0);
    // random traffic with one mid-stream reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 0;
        observe();
        chk("p1 rst busy", 32'(busy), 0);
        chk("p1 rst mem_en", 32'(mem_en), 0);
        chk("p1 rst gnts", 32'(if_gnt | ls_gnt), 0);
        step_clk();
        clear_reqs();
        rst = 1;
        observe();
        chk("p1 idle mem_en", 32'(mem_en), 0);
        step_clk();
      end
      drive_rand();
      observe();
      step_clk();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: instruction fetch (IF) and the load/store path (LS, driven by the decoder's ram_re/ram_we).
- Issues one RAM access at a time and waits the fixed RAM read latency.
- Routes read data and a one-cycle valid pulse back to the requester that owns the access.
- Sits between the fetch/decode datapath and the RAM macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RAM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- if_req  input  1  fetch read request; held with if_addr until if_gnt.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DATA_W  fetch read data.
- ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  load/store request accepted this cycle.
- ls_rvalid  output  1  one-cycle pulse; ls_rdata valid (loads only).
- ls_rdata  output  DATA_W  load data.
- mem_en  output  1  RAM access strobe.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, valid RAM_LAT cycles after a read mem_en.
- busy  output  1  read in flight (state WAIT).

Behaviour:
- FSM has two states, IDLE and WAIT, plus registers owner (IF/LS), lat_cnt (2 bits) and prio (round-robin pointer).
- IDLE, arbitration:
  - Grants are combinational from req in IDLE; at most one gnt per cycle.
  - Fixed priority: LS beats IF.
  - Granted cycle: mem_en=1; mem_addr/mem_wdata/mem_we come from the winner. IF is always a read: mem_we=0, mem_wdata=0.
  - When not granting, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
- Store grant: completes in the grant cycle; state stays IDLE; no rvalid. Back-to-back stores can be granted every cycle.
- Read grant (IF, or LS with ls_we=0): owner latched, lat_cnt loaded with RAM_LAT-1, next state WAIT.
- WAIT:
  - No grants; all gnt=0; mem_en=0; busy=1.
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt==0, the owner's rvalid=1 and its rdata = mem_rdata (pass-through); next state is IDLE.
  - Result: rvalid arrives exactly RAM_LAT cycles after the grant cycle. Read throughput is one per RAM_LAT+1 cycles.
- rdata outputs are 0 whenever the matching rvalid=0.
- A requester dropping req before gnt is legal; the request is simply not served.
- Reset (async, any state, including mid-WAIT):
  - State goes to IDLE; lat_cnt=0; owner=IF; prio=LS.
  - All outputs 0.
  - Any pending rvalid is discarded and never emitted after reset releases.
- RAM_LAT outside 1..4 is a configuration error; flag it with a simulation-time $error.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - prio names the favoured requester; it resets to LS.
  - A contested grant goes to prio, then prio flips to the other requester.
  - An uncontested grant sets prio to the non-granted requester.
- Undefined: fixed LS-over-IF priority; the prio register is not implemented.

Test Plan:
1. Assert rst=0 mid-stream → all outputs 0, busy=0. After release with no req → mem_en stays 0.
2. RAM_LAT=1, if_req=1, if_addr=0x1C, RAM returns 0xDEADBEEF:
   - cycle0: if_gnt=1, mem_en=1, mem_addr=0x1C, mem_we=0.
   - cycle1: if_rvalid=1, if_rdata=0xDEADBEEF, busy=1.
   - cycle2: IDLE.
3. Fixed priority, RAM_LAT=2; if_req (0x100) and ls load (0x40) both asserted:
   - cycle0: ls_gnt, mem_addr=0x40.
   - cycle2: ls_rvalid.
   - cycle3: if_gnt, mem_addr=0x100.
   - cycle5: if_rvalid.
4. Three LS stores to 0x10/0x14/0x18 with wdata 1/2/3 on consecutive cycles → ls_gnt=1, mem_we=1, mem_en=1 on each of the 3 cycles with matching addr/data; no rvalid; busy=0 throughout.
5. ARB_RR_EN, RAM_LAT=1, both reads held continuously → grant order LS, IF, LS, IF (a grant every 2 cycles). Without ARB_RR_EN, the same stimulus → LS only and IF starved.
6. RAM_LAT=3: LS load granted, then rst asserted 1 cycle later and released → ls_rvalid/if_rvalid never pulse; busy=0; next if_req is granted on the first cycle after release.
